// File: rtl/jedro_1_pkg.sv
// Shared encodings and default widths for the jedro_1 writeback path.
package jedro_1_pkg;

    localparam logic [1:0] LSU_W_BYTE = 2'b00;
    localparam logic [1:0] LSU_W_HALF = 2'b01;
    localparam logic [1:0] LSU_W_WORD = 2'b10;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_ALU_FIFO_DEPTH = 2;

endpackage : jedro_1_pkg

// File: rtl/jedro_1_wb_fifo.sv
// Small synchronous FIFO buffering ALU results while the LSU owns the write port.
module jedro_1_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state for storage and pointers; push and pop may coincide.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule : jedro_1_wb_fifo

// File: rtl/jedro_1_writeback.sv
// Register file write port C master: merges ALU results and load returns,
// extends load data, and tracks outstanding load destinations.
module jedro_1_writeback
    import jedro_1_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = $clog2(DATA_WIDTH),
    parameter int ALU_FIFO_DEPTH = DEFAULT_ALU_FIFO_DEPTH
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        alu_valid_i,
    output logic                        alu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0]   alu_dest_i,
    input  logic [DATA_WIDTH-1:0]       alu_data_i,
    input  logic                        lsu_valid_i,
    output logic                        lsu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0]   lsu_dest_i,
    input  logic [DATA_WIDTH-1:0]       lsu_data_i,
    input  logic [1:0]                  lsu_width_i,
    input  logic                        lsu_unsigned_i,
    input  logic [1:0]                  lsu_offset_i,
    input  logic                        ld_issue_i,
    input  logic [REG_ADDR_WIDTH-1:0]   ld_issue_dest_i,
    output logic [REG_ADDR_WIDTH-1:0]   wpc_addr_o,
    output logic [DATA_WIDTH-1:0]       wpc_data_o,
    output logic                        wpc_we_o,
    output logic [2**REG_ADDR_WIDTH-1:0] busy_o
);

    localparam int NUM_REGISTERS = 2**REG_ADDR_WIDTH;
    localparam int FIFO_W        = REG_ADDR_WIDTH + DATA_WIDTH;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [FIFO_W-1:0]         fifo_head;
    logic [REG_ADDR_WIDTH-1:0] head_dest;
    logic [DATA_WIDTH-1:0]     head_data;

    logic                      alu_side_valid;
    logic                      lsu_wins;
    logic                      alu_wins;
    logic                      alu_xfer;
    logic                      lsu_xfer;
    logic                      bypass;

    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [DATA_WIDTH-1:0]     ld_ext;

    logic [REG_ADDR_WIDTH-1:0] win_dest;
    logic [DATA_WIDTH-1:0]     win_data;

    logic [REG_ADDR_WIDTH-1:0] wpc_addr_q, wpc_addr_d;
    logic [DATA_WIDTH-1:0]     wpc_data_q, wpc_data_d;
    logic                      wpc_we_q, wpc_we_d;
    logic [NUM_REGISTERS-1:0]  busy_q, busy_d;

    assign {head_dest, head_data} = fifo_head;

    // Arbitration: LSU normally wins, except a full ALU buffer takes priority
    // so ALU results cannot be starved behind a stream of loads.
    always_comb begin
        alu_side_valid = alu_valid_i | ~fifo_empty;
        lsu_wins       = lsu_valid_i & ~fifo_full;
        alu_wins       = ~lsu_wins & alu_side_valid;
        alu_ready_o    = ~fifo_full;
        lsu_ready_o    = lsu_wins;
        alu_xfer       = alu_valid_i & ~fifo_full;
        lsu_xfer       = lsu_wins;
        bypass         = alu_wins & fifo_empty;
        fifo_push      = alu_xfer & ~bypass;
        fifo_pop       = alu_wins & ~fifo_empty;
    end

    // Load data extraction and sign/zero extension.
    always_comb begin
        ld_byte = lsu_data_i[{lsu_offset_i, 3'b000} +: 8];
        ld_half = lsu_data_i[{lsu_offset_i[1], 4'b0000} +: 16];
        case (lsu_width_i)
            LSU_W_BYTE: ld_ext = {{(DATA_WIDTH-8){~lsu_unsigned_i & ld_byte[7]}}, ld_byte};
            LSU_W_HALF: ld_ext = {{(DATA_WIDTH-16){~lsu_unsigned_i & ld_half[15]}}, ld_half};
            default:    ld_ext = lsu_data_i;
        endcase
    end

    // Winner payload and next output-register contents.
    always_comb begin
        if (lsu_wins) begin
            win_dest = lsu_dest_i;
            win_data = ld_ext;
        end else if (fifo_empty) begin
            win_dest = alu_dest_i;
            win_data = alu_data_i;
        end else begin
            win_dest = head_dest;
            win_data = head_data;
        end
        wpc_addr_d = wpc_addr_q;
        wpc_data_d = wpc_data_q;
        wpc_we_d   = 1'b0;
        if (lsu_wins || alu_wins) begin
            wpc_addr_d = win_dest;
            wpc_data_d = win_data;
            wpc_we_d   = (win_dest != '0);
        end
    end

    // Scoreboard: returning load clears its bit, a newly issued load sets it;
    // set is applied last so it wins on the same index.
    always_comb begin
        busy_d = busy_q;
        if (lsu_xfer) begin
            busy_d[lsu_dest_i] = 1'b0;
        end
        if (ld_issue_i && (ld_issue_dest_i != '0)) begin
            busy_d[ld_issue_dest_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output and scoreboard registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wpc_addr_q <= '0;
            wpc_data_q <= '0;
            wpc_we_q   <= 1'b0;
            busy_q     <= '0;
        end else begin
            wpc_addr_q <= wpc_addr_d;
            wpc_data_q <= wpc_data_d;
            wpc_we_q   <= wpc_we_d;
            busy_q     <= busy_d;
        end
    end

    assign wpc_addr_o = wpc_addr_q;
    assign wpc_data_o = wpc_data_q;
    assign wpc_we_o   = wpc_we_q;
    assign busy_o     = busy_q;

    jedro_1_wb_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (ALU_FIFO_DEPTH)
    ) u_alu_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  ({alu_dest_i, alu_data_i}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule : jedro_1_writeback

// File: doc/jedro_1_writeback.md
Name: jedro_1_writeback

Overview:
Write-side master for the integer register file write port C (addr/data/we). It merges ALU results and LSU load returns into one registered write per cycle. Load data is byte/halfword extracted and sign- or zero-extended here. A busy scoreboard of outstanding load destinations is exported to decode for RAW stalls.

Parameters:
DATA_WIDTH, 32, data word width
REG_ADDR_WIDTH, $clog2(DATA_WIDTH), register index width; NUM_REGISTERS = 2**REG_ADDR_WIDTH
ALU_FIFO_DEPTH, 2, ALU result buffer entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; synchronous, active-low
alu_valid_i  in  1  ALU result valid
alu_ready_o  out  1  ALU result accepted
alu_dest_i  in  REG_ADDR_WIDTH  ALU destination register
alu_data_i  in  DATA_WIDTH  ALU result
lsu_valid_i  in  1  load data valid
lsu_ready_o  out  1  load data accepted
lsu_dest_i  in  REG_ADDR_WIDTH  load destination register
lsu_data_i  in  DATA_WIDTH  raw aligned memory word
lsu_width_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
lsu_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend
lsu_offset_i  in  2  byte address bits [1:0]
ld_issue_i  in  1  decode issued a load this cycle
ld_issue_dest_i  in  REG_ADDR_WIDTH  destination of the issued load
wpc_addr_o  out  REG_ADDR_WIDTH  register file write address
wpc_data_o  out  DATA_WIDTH  register file write data
wpc_we_o  out  1  register file write enable
busy_o  out  NUM_REGISTERS  bit n = load pending to xn; bit 0 is always 0

Behaviour:
- Reset (rstn_i low at posedge): wpc_addr_o=0, wpc_data_o=0, wpc_we_o=0, busy_o=0, FIFO empty. Reset overrides every other event in the same cycle, including a mid-transfer handshake.
- Handshake: a transfer occurs on a posedge when valid & ready are both high. A source holds valid and its payload stable until the transfer.
- alu_ready_o = !fifo_full. It depends only on state and never on alu_valid_i.
- Arbitration each cycle, candidates LSU and ALU-side (FIFO head if non-empty, else direct alu input):
  - FIFO full and lsu_valid_i: ALU-side wins (starvation guard).
  - Otherwise, lsu_valid_i: LSU wins.
  - Otherwise: ALU-side wins.
- lsu_ready_o = lsu_valid_i & LSU wins.
- ALU bypass: FIFO empty and ALU-side wins -> alu input goes straight to the output register and is not enqueued.
- ALU enqueue: ALU transfer not consumed directly -> enqueued. Dequeue of the head and enqueue may occur in the same cycle; occupancy is unchanged.
- Output register: at the posedge after selection, wpc_addr_o/wpc_data_o take the winner's values. wpc_we_o = (winner exists) & (dest != 0). x0 is never written. Latency is 1 cycle from the transfer edge; one write per cycle maximum.
- When no winner, wpc_we_o=0 and wpc_addr_o/wpc_data_o hold their previous values.
- Load extraction: byte = lsu_data_i[8*offset +: 8]. Half = lsu_data_i[16*offset[1] +: 16]; offset[0] is ignored. Word ignores offset. Upper bits are filled with zeros if lsu_unsigned_i is high, else with the extracted MSB.
- Scoreboard:
  - At the posedge, ld_issue_i with dest != 0 sets busy[dest].
  - An LSU transfer clears busy[lsu_dest_i].
  - Set and clear of the same index in one cycle: set wins.
  - Clear of a non-busy bit is a no-op. busy_o[0] is tied 0.
- Decode guarantees it issues no writer to a busy register. This block performs no write-order reordering beyond the above.

Decomposition:
- Package jedro_1_pkg holds: LSU width encodings (LSU_W_BYTE=2'b00, LSU_W_HALF=2'b01, LSU_W_WORD=2'b10) and default widths.
- Sub-module jedro_1_wb_fifo: synchronous FIFO with parameterized width/depth, full/empty flags, simultaneous push/pop. Reset is synchronous active-low. Used for the ALU buffer with payload {dest, data}.
- Load extraction and the scoreboard stay inline.

Test Plan:
- Reset is held while alu_valid_i=1 and ld_issue_i=1 -> wpc_we_o=0, busy_o=0, alu_ready_o=1 on the first cycle after release.
- ALU alone: dest=5, data=32'hDEADBEEF, FIFO empty -> next cycle wpc_we_o=1, addr=5, data=DEADBEEF; alu_ready_o stays 1.
- ALU and LSU collide for 3 cycles: LSU to x7/x8/x9, ALU to x1/x2/x3. Expect the first two ALU results queued, then alu_ready_o=0. Third cycle: ALU head x1 wins, lsu_ready_o=0. Total writes appear in order x7, x8, x1, x9, x2, x3 and none are lost.
- Load extraction with lsu_data_i=32'h80F1_7F82:
  - byte, offset 0, signed -> FFFFFF82
  - byte, offset 1, unsigned -> 0000007F
  - half, offset 2, signed -> FFFF80F1
  - half, offset 3 -> same as offset 2
  - word -> 80F17F82
- Scoreboard: issue load to x10 -> busy_o[10]=1. LSU transfer to x10 in the same cycle as a new ld_issue to x10 -> busy_o[10] remains 1. Later LSU transfer clears it. ld_issue to x0 -> busy_o unchanged.
- Writes with dest=0 from ALU and LSU -> wpc_we_o=0, handshakes still complete (ready high), x0 busy bit never set.
